fifo_drain_ctrl: RTL and testbench

//  Read-side controller for the async FIFO. Pops words from the FIFO read port

---
 rtl/fifo_drain_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller for the async FIFO: paced or button-stepped pops,
// with the popped word shown on LEDs, a popped-word count and a sticky underflow flag.

module fifo_drain_ctrl_chk #(
    parameter int DSIZE       = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rempty,
    input  logic             rinc,
    input  logic             in_hold,
    input  logic [DSIZE-1:0] leds,
    input  logic [DSIZE-1:0] rdata
);

    // A pop strobe must never reach an empty FIFO.
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (reset)
        !(rinc && rempty));

    // The strobe lasts one cycle and the controller is already holding while it is high.
    a_rinc_one_cycle: assert property (@(posedge clk) disable iff (reset)
        rinc |=> !rinc);

    a_rinc_in_hold: assert property (@(posedge clk) disable iff (reset)
        rinc |-> in_hold);

    // The word shown while the strobe is high is the word being removed.
    a_leds_match_head: assert property (@(posedge clk) disable iff (reset)
        rinc |-> (leds == rdata));

endmodule

module fifo_drain_ctrl #(
    parameter int DSIZE       = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    input  logic             step_btn,
    input  logic             auto_mode,
    output logic             rinc,
    output logic [DSIZE-1:0] leds,
    output logic             valid_led,
    output logic             underflow_led,
    output logic [CNT_W-1:0] pop_count
);

    localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_n_s;
    logic [HW-1:0]     hold_cnt_r;
    logic [HW-1:0]     hold_n_s;
    logic              step_q_r;
    logic              step_rise_s;
    logic              req_s;
    logic              pop_s;
    logic              uflow_set_s;
    logic              rinc_r;
    logic [DSIZE-1:0]  leds_r;
    logic              valid_r;
    logic              underflow_r;
    logic [CNT_W-1:0]  pop_count_r;

    // Next-state, pop decision and underflow detection.
    always_comb begin
        step_rise_s = step_btn & ~step_q_r;
        req_s       = auto_mode | step_rise_s;
        state_n_s   = state_r;
        hold_n_s    = hold_cnt_r;
        pop_s       = 1'b0;
        uflow_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s && !rempty) begin
                    pop_s     = 1'b1;
                    state_n_s = ST_HOLD;
                    hold_n_s  = HW'(HOLD_CYCLES - 1);
                end else if (step_rise_s && rempty) begin
                    uflow_set_s = 1'b1;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            // Requests arriving here are dropped; the hold gives rempty time to settle.
            ST_HOLD: begin
                if (hold_cnt_r == {HW{1'b0}}) begin
                    state_n_s = ST_IDLE;
                end else begin
                    hold_n_s = hold_cnt_r - HW'(1);
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                hold_n_s  = {HW{1'b0}};
            end
        endcase
    end

    // State, edge-detect and hold counter registers.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= {HW{1'b0}};
            step_q_r   <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            hold_cnt_r <= hold_n_s;
            step_q_r   <= step_btn;
        end
    end

    // Registered outputs; the popped word is captured on the same edge the strobe rises.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            rinc_r      <= 1'b0;
            leds_r      <= {DSIZE{1'b0}};
            valid_r     <= 1'b0;
            underflow_r <= 1'b0;
            pop_count_r <= {CNT_W{1'b0}};
        end else begin
            rinc_r <= pop_s;
            if (pop_s) begin
                leds_r      <= rdata;
                valid_r     <= 1'b1;
                pop_count_r <= pop_count_r + CNT_W'(1);
            end else begin
                leds_r      <= leds_r;
                valid_r     <= valid_r;
                pop_count_r <= pop_count_r;
            end
            if (uflow_set_s) begin
                underflow_r <= 1'b1;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    assign rinc          = rinc_r;
    assign leds          = leds_r;
    assign valid_led     = valid_r;
    assign underflow_led = underflow_r;
    assign pop_count     = pop_count_r;

    fifo_drain_ctrl_chk #(
        .DSIZE       (DSIZE),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_chk (
        .clk     (clk_100MHz),
        .reset   (reset),
        .rempty  (rempty),
        .rinc    (rinc_r),
        .in_hold (state_r == ST_HOLD),
        .leds    (leds_r),
        .rdata   (rdata)
    );

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Scoreboard bench for fifo_drain_ctrl: a small FIFO model feeds two DUT copies
// (8-bit and 2-bit counters); a monitor checks every pop against queued expectations.

module tb_fifo_drain_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       step_btn;
    logic       auto_mode;
    logic [2:0] mem [256];
    logic [7:0] wptr;
    logic [7:0] rptr;
    logic       rempty;
    logic [2:0] rdata;

    logic       rinc, rinc2;
    logic [2:0] leds, leds2;
    logic       valid_led, valid_led2;
    logic       underflow_led, underflow_led2;
    logic [7:0] pop_count;
    logic [1:0] pop_count2;

    typedef struct {
        logic [2:0] data;
        int         cnt;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   exp_pops = 0;
    int   cyc = 0;
    int   last_pop_cyc = 0;

    always #5 clk = ~clk;

    assign rempty = (rptr == wptr);
    assign rdata  = mem[rptr];

    // FIFO read pointer model.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (flush) rptr <= wptr;
        else if (rinc) rptr <= rptr + 8'd1;
    end

    fifo_drain_ctrl #(.DSIZE(3), .HOLD_CYCLES(4), .CNT_W(8)) u_dut (
        .clk_100MHz(clk), .reset(reset), .rempty(rempty), .rdata(rdata),
        .step_btn(step_btn), .auto_mode(auto_mode), .rinc(rinc), .leds(leds),
        .valid_led(valid_led), .underflow_led(underflow_led), .pop_count(pop_count));

    fifo_drain_ctrl #(.DSIZE(3), .HOLD_CYCLES(4), .CNT_W(2)) u_dut2 (
        .clk_100MHz(clk), .reset(reset), .rempty(rempty), .rdata(rdata),
        .step_btn(step_btn), .auto_mode(auto_mode), .rinc(rinc2), .leds(leds2),
        .valid_led(valid_led2), .underflow_led(underflow_led2), .pop_count(pop_count2));

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every pop strobe is matched against the next scoreboard entry.
    always @(negedge clk) begin
        if (rinc) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pop_leds", int'(leds), int'(e.data));
                check("pop_count", int'(pop_count), e.cnt % 256);
                check("pop_count_w2", int'(pop_count2), e.cnt % 4);
                check("pop_valid_led", int'(valid_led), 1);
                check("pop_rempty", int'(rempty), 0);
                check("dut2_rinc", int'(rinc2), 1);
                if (e.gap != 0) check("pop_spacing", cyc - last_pop_cyc, e.gap);
            end
            last_pop_cyc = cyc;
        end
    end

    task automatic do_reset();
        reset = 1'b1; flush = 1'b1; step_btn = 1'b0; auto_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; flush = 1'b0;
        sb.delete();
        exp_pops = 0;
    endtask

    task automatic load(input logic [2:0] w, input int gap);
        exp_t e;
        mem[wptr] = w;
        wptr = wptr + 8'd1;
        exp_pops++;
        e.data = w; e.cnt = exp_pops; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic press();
        step_btn = 1'b1;
        @(posedge clk); #1;
        step_btn = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc && sb.size() != 0; i++) @(posedge clk);
        #1;
        check(name, sb.size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        wptr = 8'd0;
        rptr = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = 3'd0;

        // 1: reset state, then step on an empty FIFO -> underflow only
        do_reset();
        check("rst_rinc", int'(rinc), 0);
        check("rst_leds", int'(leds), 0);
        check("rst_valid", int'(valid_led), 0);
        check("rst_uflow", int'(underflow_led), 0);
        check("rst_count", int'(pop_count), 0);
        step_btn = 1'b1;
        idle(2);
        step_btn = 1'b0;
        idle(3);
        check("t1_uflow", int'(underflow_led), 1);
        check("t1_leds", int'(leds), 0);
        check("t1_count", int'(pop_count), 0);
        check("t1_valid", int'(valid_led), 0);

        // 2: auto drain of 5,2,7 at a 5-cycle pace
        do_reset();
        load(3'd5, 0); load(3'd2, 5); load(3'd7, 5);
        auto_mode = 1'b1;
        @(posedge clk); #1;
        check("t2_first_latency", int'(rinc), 1);
        wait_drain("t2_drain", 40);
        idle(8);
        check("t2_uflow", int'(underflow_led), 0);
        check("t2_leds_held", int'(leds), 7);
        check("t2_count", int'(pop_count), 3);
        check("t2_rempty", int'(rempty), 1);
        auto_mode = 1'b0;

        // 3: button held for 20 cycles -> a single pop
        do_reset();
        load(3'd3, 0);
        mem[wptr] = 3'd4; wptr = wptr + 8'd1;
        step_btn = 1'b1;
        idle(20);
        step_btn = 1'b0;
        idle(4);
        wait_drain("t3_drain", 5);
        check("t3_leds", int'(leds), 3);
        check("t3_count", int'(pop_count), 1);

        // 4: second press during HOLD is dropped
        do_reset();
        load(3'd1, 0);
        mem[wptr] = 3'd6; wptr = wptr + 8'd1;
        press();
        idle(1);
        press();
        idle(10);
        wait_drain("t4_drain", 5);
        check("t4_count", int'(pop_count), 1);
        check("t4_uflow", int'(underflow_led), 0);
        check("t4_leds", int'(leds), 1);

        // 5: reset in HOLD clears everything; no pop until a new request
        do_reset();
        load(3'd6, 0);
        mem[wptr] = 3'd5; wptr = wptr + 8'd1;
        press();
        idle(1);
        check("t5_leds_before", int'(leds), 6);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5_rinc", int'(rinc), 0);
        check("t5_leds", int'(leds), 0);
        check("t5_valid", int'(valid_led), 0);
        check("t5_uflow", int'(underflow_led), 0);
        check("t5_count", int'(pop_count), 0);
        reset = 1'b0;
        sb.delete();
        exp_pops = 0;
        idle(10);
        load_expect_only(3'd5);
        press();
        wait_drain("t5_drain", 10);
        check("t5_leds_after", int'(leds), 5);

        // 6: five pops, the 2-bit counter wraps 1,2,3,0,1
        do_reset();
        load(3'd1, 0); load(3'd2, 5); load(3'd3, 5); load(3'd4, 5); load(3'd5, 5);
        auto_mode = 1'b1;
        wait_drain("t6_drain", 60);
        auto_mode = 1'b0;
        idle(6);
        check("t6_count", int'(pop_count), 5);
        check("t6_count_w2", int'(pop_count2), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    task automatic load_expect_only(input logic [2:0] w);
        exp_t e;
        exp_pops++;
        e.data = w; e.cnt = exp_pops; e.gap = 0;
        sb.push_back(e);
    endtask

endmodule
